// File: rtl/frogger_pkg.sv
// Shared frogger definitions: move directions (also used by the frog controller
// and sprite orientation) and the repeat FSM state encoding.
package frogger_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'b00,
    RPT_DELAY  = 2'b01,
    RPT_REPEAT = 2'b10
  } rpt_state_e;

  // Fixed priority for same-cycle presses: up > down > left > right.
  function automatic dir_e pick_dir(input logic [3:0] p);
    if (p[0]) return DIR_UP;
    else if (p[1]) return DIR_DOWN;
    else if (p[2]) return DIR_LEFT;
    else return DIR_RIGHT;
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// One raw switch: 2-flop synchroniser followed by a consecutive-cycle debouncer.
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic stable
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // stable flips on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle;
  // any agreeing cycle restarts the count, so cnt never passes LAST.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 != stable) begin
        if (cnt == LAST) begin
          stable <= ~stable;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/frog_move_input.sv
// Switch front end for the frog controller: debounce, press detect, priority
// arbitration, hold-to-repeat and a single-entry valid/ready command register.
module frog_move_input
  import frogger_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 6250000,
  parameter int REPEAT_PERIOD   = 3125000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       switch1,
  input  logic       switch2,
  input  logic       switch3,
  input  logic       switch4,
  input  logic       lock,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic [3:0] switch_state,
  output logic [1:0] dbg_state
);

  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;
  localparam logic [TW-1:0] DELAY_LOAD  = TW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [TW-1:0] PERIOD_LOAD = TW'(REPEAT_PERIOD - 1);
  localparam bit REPEAT_EN = (REPEAT_DELAY > 0);

  logic [3:0]    sw_raw;
  logic [3:0]    stable_d;
  logic [3:0]    press;
  logic          press_any;
  dir_e          press_dir;
  dir_e          held_dir;
  dir_e          cmd_dir;
  rpt_state_e    state;
  logic [TW-1:0] timer;
  logic          rpt_fire;
  logic          issue_press;
  logic          issue_rpt;

  assign sw_raw = {switch4, switch3, switch2, switch1};

  for (genvar i = 0; i < 4; i++) begin : g_deb
    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (sw_raw[i]),
      .stable (switch_state[i])
    );
  end

  assign press     = switch_state & ~stable_d;
  assign press_any = |press;
  assign press_dir = pick_dir(press);

  // A repeat only fires while its direction is still held; a press beats a
  // repeat for the output register in the same cycle.
  assign rpt_fire    = (state != RPT_IDLE) && (timer == '0) && switch_state[held_dir];
  assign issue_press = !lock && !move_valid && press_any;
  assign issue_rpt   = !lock && !move_valid && !press_any && rpt_fire;
  assign cmd_dir     = press_any ? press_dir : held_dir;
  assign dbg_state   = state;

  // Handshake: move_valid/move_dir are held stable until an edge sees
  // move_valid && move_ready; that edge clears move_valid, and a new command
  // may load no earlier than the following edge (commands arising while the
  // register is occupied are dropped).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_d   <= 4'b0000;
      move_valid <= 1'b0;
      move_dir   <= DIR_UP;
      state      <= RPT_IDLE;
      timer      <= '0;
      held_dir   <= DIR_UP;
    end else begin
      stable_d <= switch_state;
      if (lock) begin
        move_valid <= 1'b0;
        state      <= RPT_IDLE;
        timer      <= '0;
      end else begin
        if (move_valid && move_ready) move_valid <= 1'b0;
        if (issue_press || issue_rpt) begin
          move_valid <= 1'b1;
          move_dir   <= cmd_dir;
        end
        case (state)
          RPT_IDLE: begin
            if (issue_press && REPEAT_EN) begin
              state    <= RPT_DELAY;
              timer    <= DELAY_LOAD;
              held_dir <= press_dir;
            end
          end
          RPT_DELAY, RPT_REPEAT: begin
            if (issue_press && (press_dir < held_dir)) begin
              state    <= RPT_DELAY;
              timer    <= DELAY_LOAD;
              held_dir <= press_dir;
            end else if (!switch_state[held_dir]) begin
              state <= RPT_IDLE;
              timer <= '0;
            end else if (timer == '0) begin
              // Period continues even if this repeat was dropped.
              state <= RPT_REPEAT;
              timer <= PERIOD_LOAD;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          default: begin
            state <= RPT_IDLE;
            timer <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frog_move_input.sv
// Directed bench for frog_move_input: one instance with repeat disabled, one
// with repeat enabled, fed the same switches. Edge 0 is the last clock edge
// before the raw input changes.
module tb_frog_move_input;

  logic       clk;
  logic       reset_n;
  logic       switch1, switch2, switch3, switch4;
  logic       lock;
  logic       move_ready;
  logic       nv_valid, rp_valid;
  logic [1:0] nv_dir, rp_dir;
  logic [3:0] nv_state, rp_state;
  logic [1:0] nv_dbg, rp_dbg;

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;

  logic [15:0] exp_q[$];
  logic [15:0] got_nv_q[$];
  logic [15:0] got_rp_q[$];

  frog_move_input #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(4)) dut_norep (
    .clk(clk), .reset_n(reset_n),
    .switch1(switch1), .switch2(switch2), .switch3(switch3), .switch4(switch4),
    .lock(lock), .move_ready(move_ready),
    .move_valid(nv_valid), .move_dir(nv_dir), .switch_state(nv_state), .dbg_state(nv_dbg)
  );

  frog_move_input #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)) dut_rep (
    .clk(clk), .reset_n(reset_n),
    .switch1(switch1), .switch2(switch2), .switch3(switch3), .switch4(switch4),
    .lock(lock), .move_ready(move_ready),
    .move_valid(rp_valid), .move_dir(rp_dir), .switch_state(rp_state), .dbg_state(rp_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk(input int e, input logic [1:0] d);
    logic [13:0] e14;
    e14 = e[13:0];
    return {e14, d};
  endfunction

  // driver tasks
  task automatic do_reset();
    reset_n = 1'b0;
    {switch4, switch3, switch2, switch1} = 4'b0000;
    lock = 1'b0;
    move_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    got_nv_q.delete();
    got_rp_q.delete();
    exp_q.delete();
  endtask

  task automatic start_edge0();
    @(posedge clk);
    #1;
    edge_cnt = 0;
  endtask

  task automatic collect(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      edge_cnt++;
      if (nv_valid) got_nv_q.push_back(mk(edge_cnt, nv_dir));
      if (rp_valid) got_rp_q.push_back(mk(edge_cnt, rp_dir));
    end
  endtask

  // scoreboard: compare an observed command list with exp_q
  task automatic score_nv(input string tag);
    check({tag, "_count"}, got_nv_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_nv_q.size() > 0)
      check({tag, "_cmd"}, got_nv_q.pop_front(), exp_q.pop_front());
    got_nv_q.delete();
    exp_q.delete();
  endtask

  task automatic score_rp(input string tag);
    check({tag, "_count"}, got_rp_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_rp_q.size() > 0)
      check({tag, "_cmd"}, got_rp_q.pop_front(), exp_q.pop_front());
    got_rp_q.delete();
    exp_q.delete();
  endtask

  initial begin
    // reset state
    do_reset();
    #2;
    check("rst_valid", nv_valid, 1'b0);
    check("rst_dir", nv_dir, 2'b00);
    check("rst_state", nv_state, 4'b0000);
    check("rst_rp_valid", rp_valid, 1'b0);
    check("rst_fsm", rp_dbg, 2'b00);

    // clean press, repeat disabled: one command at edge 7, nothing else
    do_reset();
    start_edge0();
    switch1 = 1'b1;
    collect(40);
    exp_q.push_back(mk(7, 2'b00));
    score_nv("clean");
    check("clean_level", nv_state, 4'b0001);

    // bounce: switch3 toggles every 2 cycles for 20 cycles then stays low
    do_reset();
    start_edge0();
    for (int i = 0; i < 10; i++) begin
      switch3 = ~switch3;
      collect(2);
      check("bounce_level", nv_state, 4'b0000);
    end
    switch3 = 1'b0;
    collect(20);
    check("bounce_level_end", nv_state, 4'b0000);
    score_nv("bounce");

    // simultaneous down + right: down wins, single command
    do_reset();
    start_edge0();
    switch2 = 1'b1;
    switch4 = 1'b1;
    collect(30);
    exp_q.push_back(mk(7, 2'b01));
    score_nv("simul");
    check("simul_level", nv_state, 4'b1010);

    // backpressure: up held pending, later right press is lost
    do_reset();
    move_ready = 1'b0;
    start_edge0();
    switch1 = 1'b1;
    collect(10);
    switch4 = 1'b1;
    collect(10);
    check("bp_valid_held", nv_valid, 1'b1);
    check("bp_dir_held", nv_dir, 2'b00);
    check("bp_level", nv_state, 4'b1001);
    got_nv_q.delete();
    move_ready = 1'b1;
    collect(1);
    check("bp_clear", nv_valid, 1'b0);
    collect(20);
    score_nv("bp_after");

    // repeat: right held, commands at 7, 15, 19, 23, 27; release after edge 25
    do_reset();
    start_edge0();
    switch4 = 1'b1;
    collect(25);
    switch4 = 1'b0;
    collect(5);
    exp_q.push_back(mk(7, 2'b11));
    exp_q.push_back(mk(15, 2'b11));
    exp_q.push_back(mk(19, 2'b11));
    exp_q.push_back(mk(23, 2'b11));
    exp_q.push_back(mk(27, 2'b11));
    score_rp("repeat");
    collect(1);
    got_rp_q.delete();
    collect(19);
    score_rp("repeat_stop");
    check("repeat_fsm_idle", rp_dbg, 2'b00);

    // asynchronous reset while a command is pending
    do_reset();
    move_ready = 1'b0;
    start_edge0();
    switch1 = 1'b1;
    collect(10);
    check("ar_pending", nv_valid, 1'b1);
    #3 reset_n = 1'b0;
    #1;
    check("ar_valid", nv_valid, 1'b0);
    check("ar_rp_valid", rp_valid, 1'b0);
    check("ar_state", nv_state, 4'b0000);

    // lock: held switch issues nothing, even after lock drops; re-press issues one
    do_reset();
    lock = 1'b1;
    start_edge0();
    switch1 = 1'b1;
    collect(20);
    check("lock_level", nv_state, 4'b0001);
    score_nv("lock_on");
    score_rp("lock_on_rp");
    lock = 1'b0;
    collect(20);
    score_nv("lock_off");
    score_rp("lock_off_rp");
    switch1 = 1'b0;
    collect(15);
    check("lock_released", nv_state, 4'b0000);
    score_nv("lock_release");
    start_edge0();
    switch1 = 1'b1;
    collect(20);
    exp_q.push_back(mk(7, 2'b00));
    score_nv("lock_repress");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
